// File: rtl/mycpu_pkg.sv
// Shared types for the mycpu datapath: destination codes and output slot states.
package mycpu_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        DEST_P0   = 2'b00,
        DEST_P1   = 2'b01,
        DEST_P2   = 2'b10,
        DEST_DROP = 2'b11
    } dest_e;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/out_slot.sv
// One-entry output buffer: a load becomes visible after the next edge.
// Same-cycle drain and load keeps it FULL; the caller must only load when empty or draining.
module out_slot
    import mycpu_pkg::*;
#(
    parameter int DW = DATA_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_load,
    input  logic          i_rdy,
    input  logic [DW-1:0] i_dat,
    output logic          o_vld,
    output logic [DW-1:0] o_dat
);

    slot_state_e   r_state;
    slot_state_e   w_state_nxt;
    logic [DW-1:0] r_dat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SLOT_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            SLOT_EMPTY: if (i_load)            w_state_nxt = SLOT_FULL;
            SLOT_FULL:  if (i_rdy && !i_load)  w_state_nxt = SLOT_EMPTY;
            default:                           w_state_nxt = SLOT_EMPTY;
        endcase
    end

    // Data is held on drain, only overwritten by a new load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dat <= '0;
        end else if (i_load) begin
            r_dat <= i_dat;
        end
    end

    assign o_vld = (r_state == SLOT_FULL);
    assign o_dat = r_dat;

endmodule

// File: rtl/demux_3x16.sv
// Registered 1-to-3 demux with a discard destination; one cycle from accept to slot valid.
// in_ready is combinational: low only while the selected slot is full and not draining.
module demux_3x16
    import mycpu_pkg::*;
#(
    parameter int DW      = DATA_W,
    parameter int DROP_CW = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  dest_e              sel_in,
    input  logic [DW-1:0]      d_in,
    output logic               v0_out,
    output logic               v1_out,
    output logic               v2_out,
    input  logic               r0_in,
    input  logic               r1_in,
    input  logic               r2_in,
    output logic [DW-1:0]      q0_out,
    output logic [DW-1:0]      q1_out,
    output logic [DW-1:0]      q2_out,
    output logic [DROP_CW-1:0] drop_count_out
);

    logic               w_up_xfer;
    logic               w_load0;
    logic               w_load1;
    logic               w_load2;
    logic               w_drop;
    logic [DROP_CW-1:0] r_drop_cnt;

    always_comb begin
        in_ready = 1'b1;
        case (sel_in)
            DEST_P0:   in_ready = !v0_out || r0_in;
            DEST_P1:   in_ready = !v1_out || r1_in;
            DEST_P2:   in_ready = !v2_out || r2_in;
            DEST_DROP: in_ready = 1'b1;
            default:   in_ready = 1'b1;
        endcase
    end

    assign w_up_xfer = in_valid && in_ready;
    assign w_load0   = w_up_xfer && (sel_in == DEST_P0);
    assign w_load1   = w_up_xfer && (sel_in == DEST_P1);
    assign w_load2   = w_up_xfer && (sel_in == DEST_P2);
    assign w_drop    = w_up_xfer && (sel_in == DEST_DROP);

    out_slot #(.DW(DW)) u_slot0 (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_load0),
        .i_rdy  (r0_in),
        .i_dat  (d_in),
        .o_vld  (v0_out),
        .o_dat  (q0_out)
    );

    out_slot #(.DW(DW)) u_slot1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_load1),
        .i_rdy  (r1_in),
        .i_dat  (d_in),
        .o_vld  (v1_out),
        .o_dat  (q1_out)
    );

    out_slot #(.DW(DW)) u_slot2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_load2),
        .i_rdy  (r2_in),
        .i_dat  (d_in),
        .o_vld  (v2_out),
        .o_dat  (q2_out)
    );

    // Saturating: the counter sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != {DROP_CW{1'b1}})) begin
            r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    assign drop_count_out = r_drop_cnt;

endmodule

// File: tb/tb_demux_3x16.sv
// Directed vector table, multi-cycle corner sequences and a randomised scoreboard run for demux_3x16.
module tb_demux_3x16;
    import mycpu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    dest_e       sel_in;
    logic [15:0] d_in;
    logic        v0_out, v1_out, v2_out;
    logic        r0_in, r1_in, r2_in;
    logic [15:0] q0_out, q1_out, q2_out;
    logic [7:0]  drop_count_out;

    int total = 0;
    int bad   = 0;

    demux_3x16 #(.DW(16), .DROP_CW(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .sel_in         (sel_in),
        .d_in           (d_in),
        .v0_out         (v0_out),
        .v1_out         (v1_out),
        .v2_out         (v2_out),
        .r0_in          (r0_in),
        .r1_in          (r1_in),
        .r2_in          (r2_in),
        .q0_out         (q0_out),
        .q1_out         (q1_out),
        .q2_out         (q2_out),
        .drop_count_out (drop_count_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  vs;
    logic [15:0] qs [3];
    assign vs    = {v2_out, v1_out, v0_out};
    assign qs[0] = q0_out;
    assign qs[1] = q1_out;
    assign qs[2] = q2_out;

    // Upstream stability while stalled.
    logic        a_stall = 1'b0;
    logic [1:0]  a_sel   = 2'b00;
    logic [15:0] a_d     = 16'h0;
    always @(posedge clk) begin
        if (rst_n && a_stall && in_valid && ((sel_in !== a_sel) || (d_in !== a_d)))
            $error("FAIL hold_stable: sel/d changed while stalled");
        a_stall <= rst_n && in_valid && !in_ready;
        a_sel   <= sel_in;
        a_d     <= d_in;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 30) $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct packed {
        logic        vld;
        logic [1:0]  sel;
        logic [15:0] d;
        logic [2:0]  r;      // {r2,r1,r0}
        logic        e_rdy;  // before the edge
        logic [2:0]  e_v;    // {v2,v1,v0} after the edge
        logic [15:0] e_q0;
        logic [15:0] e_q1;
        logic [15:0] e_q2;
        logic [7:0]  e_drop;
    } vec_t;

    vec_t vecs [16];

    task automatic drive(input logic v, input logic [1:0] s, input logic [15:0] d, input logic [2:0] r);
        in_valid = v;
        sel_in   = dest_e'(s);
        d_in     = d;
        {r2_in, r1_in, r0_in} = r;
    endtask

    logic [15:0] sbq [3][$];
    logic [7:0]  m_drop;
    logic        m_rdy;
    logic        stall;
    logic [2:0]  rr;
    int          s_idx;

    initial begin
        vecs[0]  = '{1'b1, 2'd0, 16'h1111, 3'b000, 1'b1, 3'b001, 16'h1111, 16'h0000, 16'h0000, 8'd0};
        vecs[1]  = '{1'b1, 2'd1, 16'h2222, 3'b000, 1'b1, 3'b011, 16'h1111, 16'h2222, 16'h0000, 8'd0};
        vecs[2]  = '{1'b1, 2'd2, 16'h3333, 3'b000, 1'b1, 3'b111, 16'h1111, 16'h2222, 16'h3333, 8'd0};
        vecs[3]  = '{1'b1, 2'd0, 16'hDEAD, 3'b000, 1'b0, 3'b111, 16'h1111, 16'h2222, 16'h3333, 8'd0};
        vecs[4]  = '{1'b0, 2'd0, 16'hDEAD, 3'b000, 1'b0, 3'b111, 16'h1111, 16'h2222, 16'h3333, 8'd0};
        vecs[5]  = '{1'b1, 2'd1, 16'hABCD, 3'b010, 1'b1, 3'b111, 16'h1111, 16'hABCD, 16'h3333, 8'd0};
        vecs[6]  = '{1'b1, 2'd0, 16'h5555, 3'b000, 1'b0, 3'b111, 16'h1111, 16'hABCD, 16'h3333, 8'd0};
        vecs[7]  = '{1'b1, 2'd0, 16'h5555, 3'b000, 1'b0, 3'b111, 16'h1111, 16'hABCD, 16'h3333, 8'd0};
        vecs[8]  = '{1'b1, 2'd0, 16'h5555, 3'b001, 1'b1, 3'b111, 16'h5555, 16'hABCD, 16'h3333, 8'd0};
        vecs[9]  = '{1'b1, 2'd2, 16'h7777, 3'b100, 1'b1, 3'b111, 16'h5555, 16'hABCD, 16'h7777, 8'd0};
        vecs[10] = '{1'b1, 2'd3, 16'h1234, 3'b000, 1'b1, 3'b111, 16'h5555, 16'hABCD, 16'h7777, 8'd1};
        vecs[11] = '{1'b0, 2'd1, 16'h0000, 3'b111, 1'b1, 3'b000, 16'h5555, 16'hABCD, 16'h7777, 8'd1};
        vecs[12] = '{1'b0, 2'd3, 16'h0000, 3'b000, 1'b1, 3'b000, 16'h5555, 16'hABCD, 16'h7777, 8'd1};
        vecs[13] = '{1'b1, 2'd0, 16'h0042, 3'b000, 1'b1, 3'b001, 16'h0042, 16'hABCD, 16'h7777, 8'd1};
        vecs[14] = '{1'b1, 2'd0, 16'h0043, 3'b001, 1'b1, 3'b001, 16'h0043, 16'hABCD, 16'h7777, 8'd1};
        vecs[15] = '{1'b0, 2'd0, 16'h0000, 3'b001, 1'b1, 3'b000, 16'h0043, 16'hABCD, 16'h7777, 8'd1};

        // Reset state
        rst_n = 1'b0;
        drive(1'b1, 2'd0, 16'h0000, 3'b000);
        #12;
        chk("rst_v", {29'd0, vs}, 32'd0);
        chk("rst_q0", {16'd0, q0_out}, 32'd0);
        chk("rst_q1", {16'd0, q1_out}, 32'd0);
        chk("rst_q2", {16'd0, q2_out}, 32'd0);
        chk("rst_drop", {24'd0, drop_count_out}, 32'd0);
        chk("rst_rdy", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].vld, vecs[i].sel, vecs[i].d, vecs[i].r);
            #1;
            chk($sformatf("vec%0d_rdy", i), {31'd0, in_ready}, {31'd0, vecs[i].e_rdy});
            @(negedge clk);
            chk($sformatf("vec%0d_v", i), {29'd0, vs}, {29'd0, vecs[i].e_v});
            chk($sformatf("vec%0d_q0", i), {16'd0, q0_out}, {16'd0, vecs[i].e_q0});
            chk($sformatf("vec%0d_q1", i), {16'd0, q1_out}, {16'd0, vecs[i].e_q1});
            chk($sformatf("vec%0d_q2", i), {16'd0, q2_out}, {16'd0, vecs[i].e_q2});
            chk($sformatf("vec%0d_drop", i), {24'd0, drop_count_out}, {24'd0, vecs[i].e_drop});
        end

        // Drop counter saturation: 300 more discards on top of the one above
        drive(1'b1, 2'd3, 16'hFFFF, 3'b000);
        for (int i = 0; i < 300; i++) @(negedge clk);
        #1;
        chk("sat_drop", {24'd0, drop_count_out}, 32'd255);
        chk("sat_rdy", {31'd0, in_ready}, 32'd1);
        chk("sat_v", {29'd0, vs}, 32'd0);

        // Fill all slots then reset asynchronously mid-stream
        drive(1'b1, 2'd0, 16'hA0A0, 3'b000);
        @(negedge clk);
        drive(1'b1, 2'd1, 16'hA1A1, 3'b000);
        @(negedge clk);
        drive(1'b1, 2'd2, 16'hA2A2, 3'b000);
        @(negedge clk);
        chk("pre_rst_v", {29'd0, vs}, 32'd7);
        drive(1'b0, 2'd0, 16'h0000, 3'b000);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_v", {29'd0, vs}, 32'd0);
        chk("mid_rst_q0", {16'd0, q0_out}, 32'd0);
        chk("mid_rst_q1", {16'd0, q1_out}, 32'd0);
        chk("mid_rst_q2", {16'd0, q2_out}, 32'd0);
        chk("mid_rst_drop", {24'd0, drop_count_out}, 32'd0);
        chk("mid_rst_rdy", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 2'd1, 16'hBEEF, 3'b000);
        @(negedge clk);
        chk("post_rst_v", {29'd0, vs}, 32'd2);
        chk("post_rst_q1", {16'd0, q1_out}, 32'hBEEF);
        drive(1'b0, 2'd0, 16'h0000, 3'b111);
        @(negedge clk);
        chk("post_rst_drain", {29'd0, vs}, 32'd0);

        // Randomised traffic against per-port scoreboards
        m_drop = 8'd0;
        stall  = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            if (!stall) begin
                in_valid = ($urandom_range(3) != 0);
                sel_in   = dest_e'($urandom_range(3));
                d_in     = 16'($urandom);
            end
            rr = 3'($urandom_range(7));
            {r2_in, r1_in, r0_in} = rr;
            #1;
            s_idx = int'(sel_in);
            if (s_idx == 3) m_rdy = 1'b1;
            else            m_rdy = (sbq[s_idx].size() == 0) || rr[s_idx];
            chk("rnd_rdy", {31'd0, in_ready}, {31'd0, m_rdy});
            chk("rnd_drop", {24'd0, drop_count_out}, {24'd0, m_drop});
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("rnd_v%0d", k), {31'd0, vs[k]}, {31'd0, (sbq[k].size() != 0)});
                if ((sbq[k].size() != 0) && rr[k])
                    chk($sformatf("rnd_q%0d", k), {16'd0, qs[k]}, {16'd0, sbq[k].pop_front()});
            end
            if (in_valid && m_rdy) begin
                if (s_idx == 3) begin
                    if (m_drop != 8'hFF) m_drop = m_drop + 8'd1;
                end else begin
                    sbq[s_idx].push_back(d_in);
                end
            end
            stall = in_valid && !m_rdy;
            @(negedge clk);
        end
        #1;
        chk("rnd_final_drop", {24'd0, drop_count_out}, {24'd0, m_drop});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/demux_3x16.md
# demux_3x16

Registered 1-to-3 demultiplexer for 16-bit datapath words, the write-side counterpart of the 3-input operand mux. It accepts one word per cycle under a valid/ready handshake and routes it, by a 2-bit destination select, into one of three one-entry output slots, each drained by its own valid/ready consumer. Select code 2'b11 is a discard destination, matching the mux's code-11 zero input. It sits between the ALU/load result path and the register, address and output-port write stages of mycpu.

## Interface
- DW, 16: data width.
- DROP_CW, 8: width of the discard counter.

- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream word present.
- in_ready  out  1  demux accepts the word this cycle.
- sel_in  in  2  destination: 00→port 0, 01→port 1, 10→port 2, 11→discard.
- d_in  in  DW  upstream data.
- v0_out / v1_out / v2_out  out  1  slot k holds a word.
- r0_in / r1_in / r2_in  in  1  consumer k takes the word.
- q0_out / q1_out / q2_out  out  DW  slot k data.
- drop_count_out  out  DROP_CW  number of discarded words, saturating.

## Operation
- Each port k has a one-entry slot with state EMPTY or FULL; vk_out = (state==FULL), qk_out = slot register.
- Downstream transfer on port k: vk_out && rk_in. Upstream transfer: in_valid && in_ready.
- in_ready is combinational:
  - sel_in 11: 1.
  - sel_in k: (slot k EMPTY) || (rk_in). A full slot being drained in the same cycle accepts the new word, giving full throughput.
- Slot k next state:
  - EMPTY + upstream transfer to k → FULL, load d_in.
  - FULL + downstream transfer + no upstream transfer to k → EMPTY. Data register is held, not cleared.
  - FULL + downstream transfer + upstream transfer to k → FULL, load d_in.
  - FULL + no downstream transfer → FULL, data held. Upstream is stalled if it targets k.
- An upstream transfer with sel 11 increments drop_count_out, saturating at 2^DROP_CW−1. No slot changes.
- Ports are independent. A stall on one port blocks upstream only while upstream targets that port. No ordering is enforced between ports.
- in_ready may be high while in_valid is low. Nothing changes in that case.
- Upstream must hold sel_in and d_in stable while in_valid && !in_ready. The bench checks this with an assertion.

## Timing
- Reset (asynchronous assert, synchronous release via the existing reset path): all slots EMPTY, q0..q2_out = 0, v0..v2_out = 0, drop_count_out = 0.
  - in_ready during reset follows the rule above and evaluates to 1.
  - Reset mid-operation discards all held words immediately, with no handshake.
- Latency: a word accepted at edge n appears on vk_out/qk_out after edge n, so a consumer can take it in cycle n+1.
- Throughput: one word per cycle per port when the consumer holds rk_in high.
- Same-cycle drain and refill of one slot keeps vk_out high continuously.
- Simultaneous drains on all three ports in one cycle are legal and independent.
- drop_count_out at saturation stays at all-ones. in_ready for sel 11 remains 1.

## Structure
- mycpu_pkg gains:
  - enum dest_e {DEST_P0=2'b00, DEST_P1=2'b01, DEST_P2=2'b10, DEST_DROP=2'b11}; sel_in is typed dest_e.
  - enum slot_state_e {SLOT_EMPTY, SLOT_FULL}.
  - Constant DATA_W = 16, used as the DW default.
- Sub-module out_slot: the one-entry buffer with load, drain, state and data register. It is instantiated three times.
- The top level contains the select decode, in_ready generation and the drop counter.

## Test plan
- Reset, then send sel 00, 01, 10 with d_in 16'h1111, 16'h2222, 16'h3333 on consecutive cycles, all rk_in=0.
  - Expect v0..v2 = 1 and q0..q2 = 1111/2222/3333.
  - in_ready = 0 for any further sel 00.
- Port 1 full, r1_in=1, in_valid with sel 01 and d_in 16'hABCD in the same cycle.
  - Expect in_ready=1, v1_out stays 1, q1_out=ABCD next cycle.
- Port 0 full and stalled (r0_in=0), upstream sel 00.
  - Expect in_ready=0, held until r0_in=1.
  - Then switch to sel 10: in_ready=1 and the word lands in port 2.
- 300 transfers with sel 11 and DROP_CW=8.
  - Expect no vk_out change and drop_count_out = 255, saturated.
- Assert rst_n low mid-stream with all slots full.
  - Expect v0..v2_out, q0..q2_out and drop_count_out at 0 before the next clk edge.
  - The first post-reset word loads normally.
- Randomised sel and rk_in over 10,000 cycles against a scoreboard.
  - No lost, duplicated or reordered words per port.
  - Drop count equals the number of accepted sel-11 words.
